// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control FSM and its ALU decoder.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_ADDIEX = 4'd8,
        S_ADDIWB = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    typedef enum logic [1:0] {
        PC_SEQ = 2'b00,
        PC_BR  = 2'b01,
        PC_JMP = 2'b10,
        PC_REG = 2'b11
    } pcsrc_t;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        ACLS_NONE,
        ACLS_ADD,
        ACLS_SUB,
        ACLS_FUNCT
    } alu_class_t;

    // States that hold mem_req and wait on mem_ready.
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational ALU control: maps the FSM's ALU-op class and funct to alu_ctrl plus an illegal-funct flag.
module mips_alu_decoder
    import mips_ctrl_pkg::*;
(
    input  alu_class_t i_class,
    input  logic [5:0] i_funct,
    output alu_op_t    o_alu_ctrl,
    output logic       o_illegal
);

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        o_alu_ctrl = ALU_AND;
        o_illegal  = 1'b0;
        case (i_class)
            ACLS_ADD: o_alu_ctrl = ALU_ADD;
            ACLS_SUB: o_alu_ctrl = ALU_SUB;
            ACLS_FUNCT: begin
                case (i_funct)
                    FN_ADD:  o_alu_ctrl = ALU_ADD;
                    FN_SUB:  o_alu_ctrl = ALU_SUB;
                    FN_AND:  o_alu_ctrl = ALU_AND;
                    FN_OR:   o_alu_ctrl = ALU_OR;
                    FN_SLT:  o_alu_ctrl = ALU_SLT;
                    default: o_illegal  = 1'b1;
                endcase
            end
            default: o_alu_ctrl = ALU_AND;
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM: state register, memory timeout counter and output decode.
// Define MIPS_MC_CTRL_BNE_EN to decode opcode 000101 (bne) as a branch taken on ~zero.
module mips_mc_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_we,
    output logic [1:0] pcsrc,
    output logic       ir_we,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       reg_we,
    output logic       regdst,
    output logic       memtoreg,
    output logic [1:0] alusrcb,
    output logic [2:0] alu_ctrl,
    output logic       illegal_op,
    output logic       mem_abort
);

    localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

    state_t        r_state, w_state_next;
    logic [CW-1:0] r_count, w_count_next;
    logic          w_mem_state, w_timeout, w_abort, w_is_bne, w_funct_illegal;
    alu_class_t    w_alu_class;
    alu_op_t       w_alu_op;

`ifdef MIPS_MC_CTRL_BNE_EN
    assign w_is_bne = (opcode == OP_BNE);
`else
    assign w_is_bne = 1'b0;
`endif

    assign w_mem_state = is_mem_state(r_state);
    assign w_timeout   = (MEM_TIMEOUT != 0) && (r_count == CW'(MEM_TIMEOUT - 1));
    assign w_abort     = w_mem_state && !mem_ready && w_timeout;

    // NOTE: async reset in the sensitivity list; state updates use non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
        end
    end

    // Counter only advances while stalled in the same memory state; any exit clears it.
    always_comb begin
        w_count_next = '0;
        if (w_mem_state && !mem_ready && !w_timeout && (MEM_TIMEOUT != 0))
            w_count_next = r_count + 1'b1;
    end

    always_comb begin
        w_state_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     w_state_next = (funct == FN_JR) ? S_FETCH : S_EXEC;
                    OP_LW, OP_SW: w_state_next = S_MEMADR;
                    OP_BEQ:       w_state_next = S_BRANCH;
                    OP_ADDI:      w_state_next = S_ADDIEX;
                    OP_J:         w_state_next = S_JUMP;
                    default:      w_state_next = w_is_bne ? S_BRANCH : S_FETCH;
                endcase
            end
            S_MEMADR: w_state_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_state_next = mem_ready ? S_MEMWB : (w_abort ? S_FETCH : S_MEMRD);
            S_MEMWR:  w_state_next = (mem_ready || w_abort) ? S_FETCH : S_MEMWR;
            S_EXEC:   w_state_next = w_funct_illegal ? S_FETCH : S_ALUWB;
            S_ADDIEX: w_state_next = S_ADDIWB;
            default:  w_state_next = S_FETCH;
        endcase
    end

    always_comb begin
        case (r_state)
            S_FETCH, S_MEMADR, S_ADDIEX: w_alu_class = ACLS_ADD;
            S_BRANCH:                    w_alu_class = ACLS_SUB;
            S_EXEC:                      w_alu_class = ACLS_FUNCT;
            default:                     w_alu_class = ACLS_NONE;
        endcase
    end

    mips_alu_decoder u_alu_dec (
        .i_class    (w_alu_class),
        .i_funct    (funct),
        .o_alu_ctrl (w_alu_op),
        .o_illegal  (w_funct_illegal)
    );

    // Outputs are forced low while rst is high so nothing fires during reset.
    always_comb begin
        pc_we      = 1'b0;
        pcsrc      = PC_SEQ;
        ir_we      = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        reg_we     = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrcb    = 2'b00;
        alu_ctrl   = 3'b000;
        illegal_op = 1'b0;
        mem_abort  = 1'b0;
        if (!rst) begin
            alu_ctrl  = w_alu_op;
            mem_abort = w_abort;
            case (r_state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    alusrcb = 2'b01;
                    ir_we   = mem_ready;
                    pc_we   = mem_ready;
                end
                S_DECODE: begin
                    case (opcode)
                        OP_RTYPE: begin
                            pc_we = (funct == FN_JR);
                            pcsrc = (funct == FN_JR) ? PC_REG : PC_SEQ;
                        end
                        OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: ;
                        default: illegal_op = !w_is_bne;
                    endcase
                end
                S_MEMADR, S_ADDIEX: alusrcb = 2'b10;
                S_MEMRD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                end
                S_MEMWR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    iord    = 1'b1;
                end
                S_MEMWB: begin
                    reg_we   = 1'b1;
                    memtoreg = 1'b1;
                end
                S_EXEC:   illegal_op = w_funct_illegal;
                S_ALUWB: begin
                    reg_we = 1'b1;
                    regdst = 1'b1;
                end
                S_ADDIWB: reg_we = 1'b1;
                S_BRANCH: begin
                    pcsrc = PC_BR;
                    pc_we = w_is_bne ? ~zero : zero;
                end
                S_JUMP: begin
                    pcsrc = PC_JMP;
                    pc_we = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Self-checking bench for mips_mc_ctrl: per-instruction expected traces from an instruction-level model.
module tb_mips_mc_ctrl;

    localparam int T = 4;

`ifdef MIPS_MC_CTRL_BNE_EN
    localparam bit BNE_EN = 1'b1;
`else
    localparam bit BNE_EN = 1'b0;
`endif

    typedef struct packed {
        logic       pc_we;
        logic [1:0] pcsrc;
        logic       ir_we;
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       reg_we;
        logic       regdst;
        logic       memtoreg;
        logic [1:0] alusrcb;
        logic [2:0] alu_ctrl;
        logic       illegal_op;
        logic       mem_abort;
    } outs_t;

    typedef struct packed {
        logic       rdy;
        logic       z;
        logic [5:0] op;
        logic [5:0] fn;
        outs_t      exp;
    } step_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_we, ir_we, mem_req, mem_we, iord, reg_we, regdst, memtoreg, illegal_op, mem_abort;
    logic [1:0] pcsrc, alusrcb;
    logic [2:0] alu_ctrl;
    outs_t      obs;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mips_mc_ctrl #(.MEM_TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_we(pc_we), .pcsrc(pcsrc), .ir_we(ir_we),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .reg_we(reg_we),
        .regdst(regdst), .memtoreg(memtoreg), .alusrcb(alusrcb), .alu_ctrl(alu_ctrl),
        .illegal_op(illegal_op), .mem_abort(mem_abort)
    );

    assign obs = {pc_we, pcsrc, ir_we, mem_req, mem_we, iord, reg_we, regdst,
                  memtoreg, alusrcb, alu_ctrl, illegal_op, mem_abort};

    task automatic check(input string tag, input int idx, input outs_t exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s[%0d]: observed=%05h expected=%05h", tag, idx, obs, exp);
        end
    endtask

    function automatic outs_t o_fetch(input logic rdy);
        outs_t o = '0;
        o.mem_req  = 1'b1;
        o.alusrcb  = 2'b01;
        o.alu_ctrl = 3'b010;
        o.ir_we    = rdy;
        o.pc_we    = rdy;
        return o;
    endfunction

    function automatic step_t mk(input logic rdy, input logic z, input logic [5:0] op,
                                 input logic [5:0] fn, input outs_t o);
        step_t s;
        s.rdy = rdy; s.z = z; s.op = op; s.fn = fn; s.exp = o;
        return s;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected alu_ctrl for an R-type funct; returns 0 when the funct has no ALU operation.
    function automatic logic alu_of(input logic [5:0] fn, output logic [2:0] code);
        code = 3'b000;
        case (fn)
            6'b100000: begin code = 3'b010; return 1'b1; end
            6'b100010: begin code = 3'b110; return 1'b1; end
            6'b100100: begin code = 3'b000; return 1'b1; end
            6'b100101: begin code = 3'b001; return 1'b1; end
            6'b101010: begin code = 3'b111; return 1'b1; end
            default:   return 1'b0;
        endcase
    endfunction

    // Memory phase: fw/mw waiting cycles, then ready; T or more waits means the access aborts.
    task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input int fw, input int mw);
        step_t      q[$];
        outs_t      o;
        logic [2:0] code;
        int         n;
        bit         ok;
        n = (fw >= T) ? T : fw + 1;
        for (int i = 0; i < n; i++) begin
            o = o_fetch(fw < T && i == n - 1);
            o.mem_abort = (fw >= T && i == n - 1);
            q.push_back(mk(fw < T && i == n - 1, rbit(), 6'($urandom), 6'($urandom), o));
        end
        if (fw < T) begin
            o = '0;
            ok = (op == 6'd0) || (op == 6'd35) || (op == 6'd43) || (op == 6'd4) ||
                 (op == 6'd8) || (op == 6'd2) || (BNE_EN && op == 6'd5);
            if (op == 6'd0 && fn == 6'b001000) begin
                o.pc_we = 1'b1;
                o.pcsrc = 2'b11;
                q.push_back(mk(rbit(), rbit(), op, fn, o));
            end else if (!ok) begin
                o.illegal_op = 1'b1;
                q.push_back(mk(rbit(), rbit(), op, fn, o));
            end else begin
                q.push_back(mk(rbit(), rbit(), op, fn, o));
                o = '0;
                if (op == 6'd0) begin
                    ok = alu_of(fn, code);
                    o.alu_ctrl   = code;
                    o.illegal_op = !ok;
                    q.push_back(mk(rbit(), rbit(), op, fn, o));
                    if (ok) begin
                        o = '0; o.reg_we = 1'b1; o.regdst = 1'b1;
                        q.push_back(mk(rbit(), rbit(), op, fn, o));
                    end
                end else if (op == 6'd35 || op == 6'd43) begin
                    o.alusrcb = 2'b10; o.alu_ctrl = 3'b010;
                    q.push_back(mk(rbit(), rbit(), op, fn, o));
                    n = (mw >= T) ? T : mw + 1;
                    for (int i = 0; i < n; i++) begin
                        o = '0;
                        o.mem_req   = 1'b1;
                        o.iord      = 1'b1;
                        o.mem_we    = (op == 6'd43);
                        o.mem_abort = (mw >= T && i == n - 1);
                        q.push_back(mk(mw < T && i == n - 1, rbit(), op, fn, o));
                    end
                    if (mw < T && op == 6'd35) begin
                        o = '0; o.reg_we = 1'b1; o.memtoreg = 1'b1;
                        q.push_back(mk(rbit(), rbit(), op, fn, o));
                    end
                end else if (op == 6'd4 || op == 6'd5) begin
                    o.alu_ctrl = 3'b110;
                    o.pcsrc    = 2'b01;
                    o.pc_we    = (op == 6'd4) ? z : ~z;
                    q.push_back(mk(rbit(), z, op, fn, o));
                end else if (op == 6'd8) begin
                    o.alusrcb = 2'b10; o.alu_ctrl = 3'b010;
                    q.push_back(mk(rbit(), rbit(), op, fn, o));
                    o = '0; o.reg_we = 1'b1;
                    q.push_back(mk(rbit(), rbit(), op, fn, o));
                end else begin
                    o.pcsrc = 2'b10; o.pc_we = 1'b1;
                    q.push_back(mk(rbit(), rbit(), op, fn, o));
                end
            end
        end
        foreach (q[k]) begin
            mem_ready = q[k].rdy;
            zero      = q[k].z;
            opcode    = q[k].op;
            funct     = q[k].fn;
            @(negedge clk);
            check(tag, k, q[k].exp);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [5:0] fns [5];
        logic [5:0] op, fn;
        outs_t      o;
        int         sel, fw, mw;
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

        repeat (2) @(negedge clk);
        check("reset_outs", 0, '0);
        @(posedge clk);
        #1 rst = 1'b0;

        run_instr("add",         6'd0,  6'b100000, 1'b0, 0, 0);
        run_instr("beq_taken",   6'd4,  6'd0,      1'b1, 0, 0);
        run_instr("beq_not",     6'd4,  6'd0,      1'b0, 0, 0);
        run_instr("lw_wait3",    6'd35, 6'd0,      1'b0, 0, 3);
        run_instr("fetch_abort", 6'd0,  6'b100000, 1'b0, T, 0);
        run_instr("op5_z0",      6'd5,  6'd0,      1'b0, 0, 0);
        run_instr("op5_z1",      6'd5,  6'd0,      1'b1, 0, 0);
        run_instr("j",           6'd2,  6'd0,      1'b0, 0, 0);
        run_instr("jr",          6'd0,  6'b001000, 1'b0, 0, 0);
        run_instr("sw_wait1",    6'd43, 6'd0,      1'b0, 1, 1);
        run_instr("sw_abort",    6'd43, 6'd0,      1'b0, 0, T);
        run_instr("lw_abort",    6'd35, 6'd0,      1'b0, 2, T);
        run_instr("addi",        6'd8,  6'd0,      1'b0, 0, 0);
        run_instr("bad_funct",   6'd0,  6'b111111, 1'b0, 0, 0);
        run_instr("bad_op",      6'd63, 6'd0,      1'b0, 0, 0);
        run_instr("slt_wait3",   6'd0,  6'b101010, 1'b0, 3, 0);

        // Reset while MEMRD is stalled: outputs drop at once, then a clean FETCH follows.
        opcode = 6'd35; funct = '0; mem_ready = 1'b1;
        @(posedge clk); #1 mem_ready = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        o = '0; o.mem_req = 1'b1; o.iord = 1'b1;
        check("memrd_pre_rst", 0, o);
        #1 rst = 1'b1;
        #1 check("rst_mid_memrd", 0, '0);
        @(posedge clk);
        #1 rst = 1'b0;
        run_instr("post_rst", 6'd8, 6'd0, 1'b0, 1, 0);

        for (int i = 0; i < 80; i++) begin
            sel = $urandom_range(0, 9);
            fn  = 6'($urandom);
            case (sel)
                0, 1: begin op = 6'd0; fn = fns[$urandom_range(0, 4)]; end
                2:    begin op = 6'd0; if (rbit()) fn = 6'b001000; end
                3:    op = 6'd35;
                4:    op = 6'd43;
                5:    op = 6'd4;
                6:    op = 6'd5;
                7:    op = 6'd8;
                8:    op = 6'd2;
                default: op = 6'($urandom);
            endcase
            fw = ($urandom_range(0, 9) == 0) ? T : $urandom_range(0, T - 1);
            mw = ($urandom_range(0, 7) == 0) ? T + 1 : $urandom_range(0, T - 1);
            run_instr("rand", op, fn, rbit(), fw, mw);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
